// File: rtl/serial_byte_receiver.sv
// Receiver for an LSB-first serial link: one data line plus an active-low bit strobe.
// Completed words are latched to diod2 and shown on two hex digits. A partial frame
// is dropped when the strobes stall mid-frame.

module serial_byte_receiver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_serial,
  input  logic                       w_strobe,
  input  logic                       w_clear,
  output logic [WIDTH-1:0]           diod1,
  output logic [WIDTH-1:0]           diod2,
  output logic [6:0]                 seven_segment1,
  output logic [6:0]                 seven_segment2,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       byte_valid,
  output logic                       frame_err
);

  localparam int unsigned CntW   = $clog2(WIDTH + 1);
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]   LastBit  = CntW'(WIDTH - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] serial_sync;
  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [SYNC_STAGES-1:0] clear_sync;
  logic                   strobe_prev_q;
  logic                   clear_prev_q;
  logic                   strobe_ev;
  logic                   clear_ev;
  logic                   rx_bit;

  logic [WIDTH-1:0]  diod1_q, diod1_d;
  logic [WIDTH-1:0]  diod2_q, diod2_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // Synchronise the pins; buttons are inverted so the chains carry "pressed".
  // Chains reset to "released" so reset release never produces a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serial_sync   <= '0;
      strobe_sync   <= '0;
      clear_sync    <= '0;
      strobe_prev_q <= 1'b0;
      clear_prev_q  <= 1'b0;
    end else begin
      serial_sync   <= {serial_sync[SYNC_STAGES-2:0], w_serial};
      strobe_sync   <= {strobe_sync[SYNC_STAGES-2:0], ~w_strobe};
      clear_sync    <= {clear_sync[SYNC_STAGES-2:0], ~w_clear};
      strobe_prev_q <= strobe_sync[SYNC_STAGES-1];
      clear_prev_q  <= clear_sync[SYNC_STAGES-1];
    end
  end

  // Press edges; data is taken at the same depth so it matches the strobe edge.
  assign strobe_ev = strobe_sync[SYNC_STAGES-1] & ~strobe_prev_q;
  assign clear_ev  = clear_sync[SYNC_STAGES-1] & ~clear_prev_q;
  assign rx_bit    = serial_sync[SYNC_STAGES-1];

  // Frame state: bit_cnt == 0 is idle, otherwise a frame is in progress.
  always_comb begin
    diod1_d = diod1_q;
    diod2_d = diod2_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    err_d   = err_q;
    valid_d = 1'b0;
    if (clear_ev) begin
      // Clear beats a coincident strobe; that bit is discarded.
      diod1_d = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      timer_d = '0;
    end else if (strobe_ev) begin
      // A strobe on the timeout cycle still wins.
      timer_d = '0;
      if (cnt_q == LastBit) begin
        diod2_d = {rx_bit, diod1_q[WIDTH-1:1]};
        valid_d = 1'b1;
        diod1_d = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end else begin
        diod1_d = {rx_bit, diod1_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
      end
    end else if (cnt_q != '0) begin
      if (timer_q == TimerMax) begin
        diod1_d = '0;
        cnt_d   = '0;
        err_d   = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  // Frame state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      diod1_q <= '0;
      diod2_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      diod1_q <= diod1_d;
      diod2_q <= diod2_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign diod1      = diod1_q;
  assign diod2      = diod2_q;
  assign bit_cnt    = cnt_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

  hex2seven_seg u_seg_lo (
    .hex (diod2_q[3:0]),
    .seg (seven_segment1)
  );

  hex2seven_seg u_seg_hi (
    .hex (diod2_q[7:4]),
    .seg (seven_segment2)
  );

endmodule

// Hex digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex2seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver (WIDTH=8, TIMEOUT=16).

module tb_serial_byte_receiver;

  logic       clk;
  logic       reset;
  logic       w_serial;
  logic       w_strobe;
  logic       w_clear;
  logic [7:0] diod1;
  logic [7:0] diod2;
  logic [6:0] seven_segment1;
  logic [6:0] seven_segment2;
  logic [3:0] bit_cnt;
  logic       byte_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int bv_count = 0;

  localparam logic [6:0] Seg0 = 7'h40;
  localparam logic [6:0] Seg3 = 7'h30;
  localparam logic [6:0] Seg5 = 7'h12;
  localparam logic [6:0] SegA = 7'h08;
  localparam logic [6:0] SegC = 7'h46;
  localparam logic [6:0] SegF = 7'h0E;

  serial_byte_receiver #(
    .WIDTH       (8),
    .TIMEOUT     (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .w_serial       (w_serial),
    .w_strobe       (w_strobe),
    .w_clear        (w_clear),
    .diod1          (diod1),
    .diod2          (diod2),
    .seven_segment1 (seven_segment1),
    .seven_segment2 (seven_segment2),
    .bit_cnt        (bit_cnt),
    .byte_valid     (byte_valid),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (byte_valid === 1'b1) bv_count++;

  task automatic send_bit(input logic b);
    @(negedge clk);
    w_serial = b;
    w_strobe = 1'b0;
    repeat (4) @(negedge clk);
    w_strobe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic test_reset;
    reset = 1'b0; w_serial = 1'b0; w_strobe = 1'b1; w_clear = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (diod1 !== 8'h00) begin errors++; $display("FAIL reset_diod1 got %h want 00", diod1); end
    checks++; if (diod2 !== 8'h00) begin errors++; $display("FAIL reset_diod2 got %h want 00", diod2); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bit_cnt); end
    checks++; if ({byte_valid, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {byte_valid, frame_err}); end
    checks++; if ({seven_segment2, seven_segment1} !== {Seg0, Seg0}) begin errors++; $display("FAIL reset_segs got %h want %h", {seven_segment2, seven_segment1}, {Seg0, Seg0}); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bit_cnt !== 4'd0 || byte_valid !== 1'b0) begin errors++; $display("FAIL release_no_event got cnt=%0d bv=%b want 0/0", bit_cnt, byte_valid); end
  endtask

  task automatic test_byte_a5;
    int bv0;
    bv0 = bv_count;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    checks++; if (diod1 !== 8'h50) begin errors++; $display("FAIL a5_partial_diod1 got %h want 50", diod1); end
    checks++; if (bit_cnt !== 4'd4) begin errors++; $display("FAIL a5_partial_cnt got %0d want 4", bit_cnt); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (diod2 !== 8'hA5) begin errors++; $display("FAIL a5_diod2 got %h want a5", diod2); end
    checks++; if (bv_count - bv0 !== 1) begin errors++; $display("FAIL a5_valid_cycles got %0d want 1", bv_count - bv0); end
    checks++; if (seven_segment1 !== Seg5) begin errors++; $display("FAIL a5_seg1 got %h want %h", seven_segment1, Seg5); end
    checks++; if (seven_segment2 !== SegA) begin errors++; $display("FAIL a5_seg2 got %h want %h", seven_segment2, SegA); end
    checks++; if (bit_cnt !== 4'd0 || diod1 !== 8'h00) begin errors++; $display("FAIL a5_idle got cnt=%0d d1=%h want 0/00", bit_cnt, diod1); end
  endtask

  task automatic test_timeout;
    int bv0;
    bv0 = bv_count;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    repeat (20) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", frame_err); end
    checks++; if (bit_cnt !== 4'd0 || diod1 !== 8'h00) begin errors++; $display("FAIL to_drop got cnt=%0d d1=%h want 0/00", bit_cnt, diod1); end
    checks++; if (diod2 !== 8'hA5) begin errors++; $display("FAIL to_diod2 got %h want a5", diod2); end
    checks++; if (bv_count !== bv0) begin errors++; $display("FAIL to_no_valid got %0d want %0d", bv_count, bv0); end
  endtask

  task automatic test_ff_clears_err;
    int bv0;
    bv0 = bv_count;
    send_byte(8'hFF);
    checks++; if (diod2 !== 8'hFF) begin errors++; $display("FAIL ff_diod2 got %h want ff", diod2); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ff_err got %b want 0", frame_err); end
    checks++; if (bv_count - bv0 !== 1) begin errors++; $display("FAIL ff_valid got %0d want 1", bv_count - bv0); end
    checks++; if ({seven_segment2, seven_segment1} !== {SegF, SegF}) begin errors++; $display("FAIL ff_segs got %h want %h", {seven_segment2, seven_segment1}, {SegF, SegF}); end
  endtask

  task automatic test_clear_vs_strobe;
    int bv0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    checks++; if (bit_cnt !== 4'd5) begin errors++; $display("FAIL clr_pre_cnt got %0d want 5", bit_cnt); end
    bv0 = bv_count;
    @(negedge clk);
    w_serial = 1'b1; w_strobe = 1'b0; w_clear = 1'b0;
    repeat (4) @(negedge clk);
    w_strobe = 1'b1; w_clear = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bit_cnt !== 4'd0 || diod1 !== 8'h00) begin errors++; $display("FAIL clr_state got cnt=%0d d1=%h want 0/00", bit_cnt, diod1); end
    checks++; if (diod2 !== 8'hFF || bv_count !== bv0) begin errors++; $display("FAIL clr_keep_d2 got %h bv=%0d want ff bv=%0d", diod2, bv_count, bv0); end
  endtask

  task automatic test_held_strobe;
    @(negedge clk);
    w_serial = 1'b1; w_strobe = 1'b0;
    repeat (18) @(negedge clk);
    checks++; if (bit_cnt !== 4'd1 || diod1 !== 8'h80) begin errors++; $display("FAIL hold_one_bit got cnt=%0d d1=%h want 1/80", bit_cnt, diod1); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL hold_early_to got %b want 0", frame_err); end
    @(negedge clk);
    checks++; if (frame_err !== 1'b1 || bit_cnt !== 4'd0) begin errors++; $display("FAIL hold_to_at_16 got err=%b cnt=%0d want 1/0", frame_err, bit_cnt); end
    repeat (21) @(negedge clk);
    w_strobe = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL hold_no_rearm got %0d want 0", bit_cnt); end
  endtask

  task automatic test_async_reset;
    int bv0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if ({diod1, diod2} !== 16'h0000) begin errors++; $display("FAIL ar_diods got %h want 0000", {diod1, diod2}); end
    checks++; if ({bit_cnt, byte_valid, frame_err} !== 6'd0) begin errors++; $display("FAIL ar_ctrl got %b want 000000", {bit_cnt, byte_valid, frame_err}); end
    checks++; if ({seven_segment2, seven_segment1} !== {Seg0, Seg0}) begin errors++; $display("FAIL ar_segs got %h want %h", {seven_segment2, seven_segment1}, {Seg0, Seg0}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bv0 = bv_count;
    send_byte(8'h3C);
    checks++; if (diod2 !== 8'h3C) begin errors++; $display("FAIL ar_3c got %h want 3c", diod2); end
    checks++; if (seven_segment1 !== SegC || seven_segment2 !== Seg3) begin errors++; $display("FAIL ar_3c_segs got %h/%h want %h/%h", seven_segment2, seven_segment1, Seg3, SegC); end
    checks++; if (bv_count - bv0 !== 1) begin errors++; $display("FAIL ar_valid got %0d want 1", bv_count - bv0); end
  endtask

  initial begin
    test_reset();
    test_byte_a5();
    test_timeout();
    test_ff_clears_err();
    test_clear_vs_strobe();
    test_held_strobe();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
